memory_judge: RTL and testbench

//  Referee that generates the 2-bit event code (ev) consumed by the memory-game turn FSM.

---
 rtl/memory_pkg.sv | 20 ++
 rtl/memory_turn_timer.sv | 35 +++
 rtl/memory_judge.sv | 195 +++++++++++++++++++
 tb/tb_memory_judge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - event codes and state encoding shared by the memory-game referee
package memory_pkg;

    localparam logic [1:0] EV_KEEP   = 2'b00;
    localparam logic [1:0] EV_SWITCH = 2'b01;
    localparam logic [1:0] EV_WIN    = 2'b10;
    localparam logic [1:0] EV_DRAW   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT1,
        S_WAIT2,
        S_SHOW,
        S_EVAL,
        S_END,
        S_FIN2,
        S_DONE
    } judge_state_t;

endpackage

// File: rtl/memory_turn_timer.sv
// rtl/memory_turn_timer.sv - idle-turn counter, one-cycle expire when TURN_CYCLES enabled cycles elapse
module memory_turn_timer #(
    parameter int TURN_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(TURN_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Independent of clear so the parent can fold expire into its own clear.
    assign expire = enable && (cnt_q == CNT_W'(TURN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_judge.sv
// rtl/memory_judge.sv - memory-game referee: board, pair evaluation, scores and ev codes
// Optional turn timeout is built when MEMORY_TIMEOUT_EN is defined.
module memory_judge
    import memory_pkg::*;
#(
    parameter int  N_CARDS     = 16,
    parameter int  SYM_W       = 3,
    parameter int  SHOW_CYCLES = 4,
    parameter int  TURN_CYCLES = 1000,
    localparam int IDX_W       = $clog2(N_CARDS),
    localparam int SCORE_W     = $clog2(N_CARDS / 2 + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               load_en,
    input  logic [IDX_W-1:0]   load_idx,
    input  logic [SYM_W-1:0]   load_sym,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_idx,
    input  logic               player,
    output logic [1:0]         ev,
    output logic [N_CARDS-1:0] face_up,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               sel_err,
    output logic               busy
);
    localparam int                 SC_W  = $clog2(SHOW_CYCLES + 1);
    localparam logic [IDX_W:0]     N_LIM = (IDX_W + 1)'(N_CARDS);
    localparam logic [N_CARDS-1:0] ONE   = N_CARDS'(1);

    judge_state_t       state_q, state_d;
    logic [SYM_W-1:0]   board_q [N_CARDS];
    logic [SYM_W-1:0]   board_d [N_CARDS];
    logic [N_CARDS-1:0] matched_q, matched_d, flipped;
    logic [IDX_W-1:0]   first_q, first_d, second_q, second_d;
    logic [SC_W-1:0]    show_cnt_q, show_cnt_d;
    logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d, cur_score, oth_score;
    logic [1:0]         ev_q, ev_d;
    logic               sel_err_q, sel_err_d, busy_q, busy_d;
    logic               sel_hit, sel_bad, timeout;

    always_comb begin
        sel_hit = 1'b0;
        for (int i = 0; i < N_CARDS; i++) begin
            if (sel_idx == IDX_W'(i)) sel_hit = matched_q[i];
        end
        sel_bad = ({1'b0, sel_idx} >= N_LIM) || sel_hit ||
                  (state_q == S_WAIT2 && sel_idx == first_q);
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        matched_d  = matched_q;
        first_d    = first_q;
        second_d   = second_q;
        show_cnt_d = show_cnt_q;
        score0_d   = score0_q;
        score1_d   = score1_q;
        ev_d       = EV_KEEP;
        sel_err_d  = 1'b0;
        cur_score  = player ? score1_q : score0_q;
        oth_score  = player ? score0_q : score1_q;
        if (load_en && state_q == S_IDLE && {1'b0, load_idx} < N_LIM) begin
            board_d[load_idx] = load_sym;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    matched_d = '0;
                    score0_d  = '0;
                    score1_d  = '0;
                    state_d   = S_WAIT1;
                end
            end
            S_WAIT1, S_WAIT2: begin
                if (sel_valid) begin
                    if (sel_bad) begin
                        sel_err_d = 1'b1;
                    end else if (state_q == S_WAIT1) begin
                        first_d = sel_idx;
                        state_d = S_WAIT2;
                    end else begin
                        second_d   = sel_idx;
                        show_cnt_d = '0;
                        state_d    = S_SHOW;
                    end
                end else if (timeout) begin
                    ev_d    = EV_SWITCH;
                    state_d = S_WAIT1;
                end
            end
            S_SHOW: begin
                if (show_cnt_q == SC_W'(SHOW_CYCLES - 1)) begin
                    state_d = S_EVAL;
                end else begin
                    show_cnt_d = show_cnt_q + SC_W'(1);
                end
            end
            S_EVAL: begin
                if (board_q[first_q] == board_q[second_q]) begin
                    matched_d = matched_q | (ONE << first_q) | (ONE << second_q);
                    if (player) score1_d = score1_q + SCORE_W'(1);
                    else        score0_d = score0_q + SCORE_W'(1);
                    state_d = (&matched_d) ? S_END : S_WAIT1;
                end else begin
                    ev_d    = EV_SWITCH;
                    state_d = S_WAIT1;
                end
            end
            S_END: begin
                if (score0_q == score1_q) begin
                    ev_d    = EV_DRAW;
                    state_d = S_DONE;
                end else if (cur_score > oth_score) begin
                    ev_d    = EV_WIN;
                    state_d = S_DONE;
                end else begin
                    // Loser made the last pair: hand the turn over, then declare the winner.
                    ev_d    = EV_SWITCH;
                    state_d = S_FIN2;
                end
            end
            S_FIN2: begin
                ev_d    = EV_WIN;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SHOW) || (state_d == S_EVAL) ||
                 (state_d == S_END)  || (state_d == S_FIN2);
    end

`ifdef MEMORY_TIMEOUT_EN
    logic turn_clear;
    assign turn_clear = (state_d == S_WAIT1 && (state_q != S_WAIT1 || timeout)) ||
                        (sel_valid && !sel_bad && (state_q == S_WAIT1 || state_q == S_WAIT2));
    memory_turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (turn_clear),
        .enable (state_q == S_WAIT1 || state_q == S_WAIT2),
        .expire (timeout)
    );
`else
    assign timeout = (TURN_CYCLES < 0);
`endif

    always_comb begin
        flipped = '0;
        if (state_q == S_WAIT2 || state_q == S_SHOW || state_q == S_EVAL) flipped = flipped | (ONE << first_q);
        if (state_q == S_SHOW || state_q == S_EVAL) flipped = flipped | (ONE << second_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            matched_q  <= '0;
            first_q    <= '0;
            second_q   <= '0;
            show_cnt_q <= '0;
            score0_q   <= '0;
            score1_q   <= '0;
            ev_q       <= EV_KEEP;
            sel_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            matched_q  <= matched_d;
            first_q    <= first_d;
            second_q   <= second_d;
            show_cnt_q <= show_cnt_d;
            score0_q   <= score0_d;
            score1_q   <= score1_d;
            ev_q       <= ev_d;
            sel_err_q  <= sel_err_d;
            busy_q     <= busy_d;
        end
    end

    // Board contents survive reset so a game can be replayed without reloading.
    always_ff @(posedge clk) begin
        board_q <= board_d;
    end

    assign ev      = ev_q;
    assign face_up = matched_q | flipped;
    assign score0  = score0_q;
    assign score1  = score1_q;
    assign sel_err = sel_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_memory_judge.sv
// tb/tb_memory_judge.sv - directed self-checking bench for memory_judge
module tb_memory_judge;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst, start, load_en, sel_valid, player;
    logic [3:0]  load_idx, sel_idx;
    logic [2:0]  load_sym;
    logic [1:0]  ev;
    logic [15:0] face_up;
    logic [3:0]  score0, score1;
    logic        sel_err, busy;

    logic        sel_valid2;
    logic [2:0]  sel_idx2;
    logic [1:0]  ev2;
    logic [5:0]  face_up2;
    logic [1:0]  score0_2, score1_2;
    logic        sel_err2, busy2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ev     = 0;

    int sym_tab [16] = '{3, 3, 1, 5, 1, 5, 0, 0, 2, 2, 4, 4, 6, 6, 7, 7};
    int pa      [8]  = '{0, 2, 3, 6, 8, 10, 12, 14};
    int pb      [8]  = '{1, 4, 5, 7, 9, 11, 13, 15};

    always #5 clk = ~clk;

    memory_judge #(.N_CARDS(16), .SYM_W(3), .SHOW_CYCLES(S), .TURN_CYCLES(20)) u_dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_idx(load_idx),
        .load_sym(load_sym), .sel_valid(sel_valid), .sel_idx(sel_idx), .player(player),
        .ev(ev), .face_up(face_up), .score0(score0), .score1(score1),
        .sel_err(sel_err), .busy(busy)
    );

    memory_judge #(.N_CARDS(6), .SYM_W(3), .SHOW_CYCLES(S), .TURN_CYCLES(20)) u_small (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_idx(load_idx[2:0]),
        .load_sym(load_sym), .sel_valid(sel_valid2), .sel_idx(sel_idx2), .player(player),
        .ev(ev2), .face_up(face_up2), .score0(score0_2), .score1(score1_2),
        .sel_err(sel_err2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic sel(input int idx);
        sel_valid = 1'b1;
        sel_idx   = 4'(idx);
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves the bench on the cycle where an EVAL result becomes visible on ev.
    task automatic flip_pair(input int a, input int b, input logic p);
        player = p;
        sel(a);
        sel(b);
        repeat (S + 1) @(negedge clk);
    endtask

    task automatic play_game(input logic [7:0] who, input int from);
        for (int k = from; k < 8; k++) begin
            flip_pair(pa[k], pb[k], who[k]);
            check("match_ev", 32'(ev), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; load_en = 1'b0; load_idx = '0; load_sym = '0;
        sel_valid = 1'b0; sel_idx = '0; player = 1'b0; sel_valid2 = 1'b0; sel_idx2 = '0;
        repeat (2) @(negedge clk);
        check("rst_ev", 32'(ev), 32'd0);
        check("rst_face", 32'(face_up), 32'd0);
        check("rst_scores", {score0, score1}, 32'd0);
        check("rst_busy_err", {busy, sel_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_idx = 4'(i); load_sym = 3'(sym_tab[i]);
            @(negedge clk);
        end
        load_en = 1'b0;
        pulse_start();

        sel_valid2 = 1'b1; sel_idx2 = 3'd7;
        @(negedge clk);
        sel_valid2 = 1'b0;
        check("range_err", 32'(sel_err2), 32'd1);
        check("range_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        check("range_pulse", 32'(sel_err2), 32'd0);
        check("range_face", 32'(face_up2), 32'd0);

        sel(0);
        sel(1);
        @(negedge clk);
        check("show_busy", 32'(busy), 32'd1);
        check("show_face", 32'(face_up), 32'h0003);
        rst = 1'b0;
        #1;
        check("midrst_ev_face", {14'd0, ev, face_up}, 32'd0);
        check("midrst_busy_err", {busy, sel_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        check("start_busy", 32'(busy), 32'd0);

        flip_pair(0, 1, 1'b0);
        check("m1_ev", 32'(ev), 32'd0);
        check("m1_face", 32'(face_up), 32'h0003);
        check("m1_score0", 32'(score0), 32'd1);

        player = 1'b0;
        sel(2);
        sel(3);
        @(negedge clk);
        check("mm_show_face", 32'(face_up), 32'h000f);
        repeat (S - 1) @(negedge clk);
        check("mm_early", 32'(ev), 32'd0);
        @(negedge clk);
        check("mm_ev", 32'(ev), 32'd1);
        check("mm_face", 32'(face_up), 32'h0003);
        @(negedge clk);
        check("mm_ev_pulse", 32'(ev), 32'd0);

        player = 1'b1;
        sel(0);
        check("inv_matched", 32'(sel_err), 32'd1);
        @(negedge clk);
        check("inv_pulse", 32'(sel_err), 32'd0);
        check("inv_nochange", 32'(face_up), 32'h0003);
        sel(2);
        check("ok_first", {sel_err, face_up}, 32'h0007);
        sel(2);
        check("inv_repeat", {sel_err, face_up}, 32'h10007);
        sel(4);
        check("ok_second", {busy, sel_err}, 32'd2);
        repeat (S + 1) @(negedge clk);
        check("m2_ev", 32'(ev), 32'd0);
        check("m2_score1", 32'(score1), 32'd1);
        check("m2_face", 32'(face_up), 32'h0017);

        player = 1'b0;
        sel(3);
        sel(5);
        sel(6);
        check("show_ignore", 32'(sel_err), 32'd0);
        repeat (S) @(negedge clk);
        check("m3_ev_face", {14'd0, ev, face_up}, 32'h003f);

        play_game(8'b0011_0000, 3);
        @(negedge clk);
        check("g1_win", 32'(ev), 32'd2);
        @(negedge clk);
        check("g1_once", 32'(ev), 32'd0);
        check("g1_scores", {score0, score1}, 32'h53);
        check("g1_face_busy", {busy, face_up}, 32'h0ffff);

        pulse_start();
        check("g2_cleared", {score0, score1, face_up}, 32'd0);
        play_game(8'b1110_0000, 0);
        @(negedge clk);
        check("g2_switch", 32'(ev), 32'd1);
        @(negedge clk);
        check("g2_win", 32'(ev), 32'd2);
        @(negedge clk);
        check("g2_after", 32'(ev), 32'd0);

        pulse_start();
        flip_pair(0, 1, 1'b0);
        pulse_start();
        check("start_ignored", {score0, score1, face_up}, 32'h100003);
        play_game(8'b1010_1010, 1);
        @(negedge clk);
        check("g3_draw", 32'(ev), 32'd3);
        check("g3_scores", {score0, score1}, 32'h44);

        pulse_start();
`ifdef MEMORY_TIMEOUT_EN
        repeat (19) begin
            @(negedge clk);
            if (ev != 2'b00) n_ev++;
        end
        check("to_early", 32'(n_ev), 32'd0);
        @(negedge clk);
        check("to_ev", 32'(ev), 32'd1);
`else
        repeat (60) begin
            @(negedge clk);
            if (ev != 2'b00) n_ev++;
        end
        check("no_timeout", 32'(n_ev), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
